mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 105 ++++++++++
 tb/tb_mem_access_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding byte/half/word load-store engine over a one-cycle-latency word memory, sub-word stores done as read-modify-write.
module mem_access_unit #(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] A,
  output logic [31:0] WD,
  output logic        MemWrite,
  input  logic [31:0] RD
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, RESP} state_t;
  state_t      state_q, state_d;
  logic        write_q, write_d, signed_q, signed_d, err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, base_q, base_d;
  logic        bad, word_store;
  logic [4:0]  sh_b, sh_h;
  logic [31:0] rd_b, rd_h, load_fmt, merge;
  always_comb begin
    bad = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
          (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
          {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);
    word_store = write_q && size_q == 2'b10;
    sh_b = {addr_q[1:0], 3'b000};
    sh_h = {addr_q[1], 4'b0000};
    rd_b = RD >> sh_b;
    rd_h = RD >> sh_h;
    load_fmt = size_q == 2'b00 ? {{24{signed_q & rd_b[7]}}, rd_b[7:0]} :
               size_q == 2'b01 ? {{16{signed_q & rd_h[15]}}, rd_h[15:0]} : RD;
    merge = size_q == 2'b00 ? (base_q & ~(32'hFF << sh_b)) | (32'(wdata_q[7:0]) << sh_b)
                            : (base_q & ~(32'hFFFF << sh_h)) | (32'(wdata_q[15:0]) << sh_h);
    req_ready  = state_q == IDLE && !reset;
    resp_valid = state_q == RESP;
    resp_rdata = rdata_q;
    resp_err   = err_q;
    A        = state_q == IDLE ? 32'd0 : {2'b00, addr_q[31:2]};
    MemWrite = !reset && ((state_q == ISSUE && word_store) || state_q == WRITE);
    WD       = state_q == WRITE ? merge : (state_q == ISSUE && word_store) ? wdata_q : 32'd0;
    state_d  = state_q;
    write_d  = write_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    base_d   = base_q;
    case (state_q)
      IDLE: if (req_valid && req_ready) begin
        write_d  = req_write;
        size_d   = req_size;
        signed_d = req_signed;
        addr_d   = req_addr;
        wdata_d  = req_wdata;
        rdata_d  = 32'd0;
        err_d    = bad;
        state_d  = bad ? RESP : ISSUE;
      end
      ISSUE: state_d = word_store ? RESP : WAIT;
      WAIT: begin
        base_d  = write_q ? RD : base_q;
        rdata_d = write_q ? 32'd0 : load_fmt;
        state_d = write_q ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP: state_d = resp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      base_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      base_q   <= base_d;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed checks of mem_access_unit against a behavioural one-cycle-latency memory.
module tb_mem_access_unit;
  logic        clk = 0, reset = 1;
  logic        req_valid = 0, req_ready, req_write = 0, req_signed = 0;
  logic [1:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        resp_valid, resp_ready = 1, resp_err;
  logic [31:0] resp_rdata, A, WD, RD;
  logic        MemWrite;
  logic [31:0] mem [0:1023];
  logic        bd_en = 0;
  logic [9:0]  bd_addr = 0;
  logic [31:0] bd_data = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wa = 0, last_wd = 0;
  int          n_cmp = 0, n_bad = 0;
  int          lat, wc0;
  logic [31:0] rd, hold;
  logic        er;

  mem_access_unit #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .A(A), .WD(WD), .MemWrite(MemWrite), .RD(RD));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (MemWrite) mem[A[9:0]] <= WD;
    RD <= mem[A[9:0]];
    if (MemWrite) begin
      wr_cnt  <= wr_cnt + 1;
      last_wa <= A;
      last_wd <= WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_en = 1; bd_addr = a; bd_data = d;
    @(posedge clk); #1 bd_en = 0;
  endtask

  task automatic xact(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] ad,
                      input logic [31:0] wd, output int l, output logic [31:0] r, output logic e);
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = ad; req_wdata = wd;
    req_valid = 1; resp_ready = 1;
    @(posedge clk); #1 req_valid = 0;
    l = 1;
    while (!resp_valid && l < 20) begin
      @(posedge clk); #1 l++;
    end
    r = resp_rdata; e = resp_err;
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 0);
    chk("rst_memwrite", {31'd0, MemWrite}, 0);
    chk("rst_A", A, 0);
    chk("rst_WD", WD, 0);
    chk("rst_rdata", resp_rdata, 0);
    @(negedge clk) reset = 0;
    #1 chk("idle_req_ready", {31'd0, req_ready}, 1);

    wc0 = wr_cnt;
    xact(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, lat, rd, er);
    chk("sw_lat", lat, 2);
    chk("sw_wr_cnt", wr_cnt - wc0, 1);
    chk("sw_A", last_wa, 4);
    chk("sw_WD", last_wd, 32'hDEADBEEF);
    chk("sw_rdata", rd, 0);
    chk("sw_err", {31'd0, er}, 0);
    xact(0, 2'b10, 0, 32'h10, 0, lat, rd, er);
    chk("lw_lat", lat, 3);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_err", {31'd0, er}, 0);

    poke(4, 32'h11223344);
    wc0 = wr_cnt;
    xact(1, 2'b00, 0, 32'h12, 32'h000000AB, lat, rd, er);
    chk("sb_lat", lat, 4);
    chk("sb_wr_cnt", wr_cnt - wc0, 1);
    chk("sb_WD", last_wd, 32'h11AB3344);
    chk("sb_mem", mem[4], 32'h11AB3344);
    chk("sb_rdata", rd, 0);

    poke(4, 32'h80FF7F01);
    xact(0, 2'b00, 1, 32'h12, 0, lat, rd, er);
    chk("lb_s_12", rd, 32'hFFFFFFFF);
    chk("lb_s_12_lat", lat, 3);
    xact(0, 2'b00, 0, 32'h12, 0, lat, rd, er);
    chk("lbu_12", rd, 32'h000000FF);
    xact(0, 2'b01, 1, 32'h12, 0, lat, rd, er);
    chk("lh_s_12", rd, 32'hFFFF80FF);
    xact(0, 2'b00, 0, 32'h11, 0, lat, rd, er);
    chk("lbu_11", rd, 32'h0000007F);
    xact(0, 2'b00, 1, 32'h13, 0, lat, rd, er);
    chk("lb_s_13", rd, 32'hFFFFFF80);
    xact(0, 2'b01, 0, 32'h10, 0, lat, rd, er);
    chk("lhu_10", rd, 32'h00007F01);
    xact(0, 2'b01, 1, 32'h10, 0, lat, rd, er);
    chk("lh_s_10", rd, 32'h00007F01);
    xact(1, 2'b01, 0, 32'h12, 32'hFFFF1234, lat, rd, er);
    chk("sh_lat", lat, 4);
    chk("sh_WD", last_wd, 32'h12347F01);
    xact(1, 2'b00, 0, 32'h10, 32'h000000EE, lat, rd, er);
    chk("sb_10_mem", mem[4], 32'h12347FEE);

    wc0 = wr_cnt;
    xact(0, 2'b01, 0, 32'h13, 0, lat, rd, er);
    chk("err_lh13_lat", lat, 1);
    chk("err_lh13_err", {31'd0, er}, 1);
    chk("err_lh13_rdata", rd, 0);
    xact(1, 2'b10, 0, 32'h6, 32'h12345678, lat, rd, er);
    chk("err_sw6_lat", lat, 1);
    chk("err_sw6_err", {31'd0, er}, 1);
    xact(1, 2'b11, 0, 32'h0, 32'h12345678, lat, rd, er);
    chk("err_sz11_lat", lat, 1);
    chk("err_sz11_err", {31'd0, er}, 1);
    xact(0, 2'b10, 0, 32'h1000, 0, lat, rd, er);
    chk("err_oob_lat", lat, 1);
    chk("err_oob_err", {31'd0, er}, 1);
    chk("err_oob_rdata", rd, 0);
    chk("err_no_write", wr_cnt - wc0, 0);
    poke(1023, 32'hCAFEF00D);
    xact(0, 2'b10, 0, 32'hFFC, 0, lat, rd, er);
    chk("last_word_lat", lat, 3);
    chk("last_word_err", {31'd0, er}, 0);
    chk("last_word_rdata", rd, 32'hCAFEF00D);

    @(negedge clk);
    req_write = 0; req_size = 2'b10; req_signed = 0; req_addr = 32'h10;
    req_valid = 1; resp_ready = 0;
    @(posedge clk); #1 req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1 lat++;
    end
    hold = resp_rdata;
    chk("bp_rdata", hold, 32'h12347FEE);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", {31'd0, resp_valid}, 1);
      chk("bp_hold", resp_rdata, hold);
      chk("bp_req_ready", {31'd0, req_ready}, 0);
    end
    @(negedge clk) resp_ready = 1;
    @(posedge clk); #1;
    chk("bp_rel_valid", {31'd0, resp_valid}, 0);
    chk("bp_rel_ready", {31'd0, req_ready}, 1);

    poke(8, 32'hAABBCCDD);
    wc0 = wr_cnt;
    @(negedge clk);
    req_write = 1; req_size = 2'b01; req_addr = 32'h20; req_wdata = 32'h5555;
    req_valid = 1;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 reset = 1;
    chk("ab_memwrite_rst", {31'd0, MemWrite}, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("ab_A", A, 0);
    chk("ab_WD", WD, 0);
    chk("ab_valid", {31'd0, resp_valid}, 0);
    chk("ab_err", {31'd0, resp_err}, 0);
    chk("ab_rdata", resp_rdata, 0);
    @(negedge clk) reset = 0;
    repeat (4) @(posedge clk);
    #1;
    chk("ab_no_write", wr_cnt - wc0, 0);
    chk("ab_mem", mem[8], 32'hAABBCCDD);
    chk("ab_idle_ready", {31'd0, req_ready}, 1);
    chk("ab_idle_valid", {31'd0, resp_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
